// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e : FSM encoding (boot / run / halt)
//   PcStep        : byte distance between consecutive 16-bit instructions
//   align_pc      : forces a byte address onto a halfword boundary
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  localparam logic [15:0] PcStep = 16'd2;

  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus between the fetch unit and the 16-bit memory bank.
//   imem_read : memread strobe, driven by the fetch unit
//   imem_addr : byte address, driven by the fetch unit
//   imem_data : combinational read data, driven by the memory
// Modports: master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if;

  logic        imem_read;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;

  modport master (
    output imem_read,
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_read,
    input  imem_addr,
    output imem_data
  );

endinterface

// File: rtl/instr_fetch_unit_pc_gen.sv
// Combinational next-PC selection for the fetch unit.
// Inputs : pc, state, stall, redirect, redirect_target, halt_detect (fetched word is HALT)
// Outputs: next_pc, take_redirect, take_fetch, enter_halt
// Redirect wins over stall and is honoured in both RUN and HALT; BOOT ignores it.
module instr_fetch_unit_pc_gen
  import instr_fetch_unit_pkg::*;
(
  input  logic [15:0]  pc,
  input  fetch_state_e state,
  input  logic         stall,
  input  logic         redirect,
  input  logic [15:0]  redirect_target,
  input  logic         halt_detect,
  output logic [15:0]  next_pc,
  output logic         take_redirect,
  output logic         take_fetch,
  output logic         enter_halt
);

  always_comb begin
    take_redirect = redirect && (state != StBoot);
    take_fetch    = (state == StRun) && !redirect && !stall;
    enter_halt    = take_fetch && halt_detect;
    next_pc       = pc;
    if (take_redirect) begin
      next_pc = align_pc(redirect_target);
    end else if (take_fetch) begin
      // Wraps modulo 2^16 by construction.
      next_pc = pc + PcStep;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of the 16-bit instruction memory.
// Holds the PC, drives the memory address/memread, and latches the returned
// word into the IF/ID register. Supports stall, redirect and a HALT state.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   stall              : hold PC and IF/ID
//   redirect_valid/
//   redirect_target    : branch/jump redirect (bit0 dropped, flagged sticky)
//   imem               : instruction memory bus (master side)
//   ifid_instr,
//   ifid_pc_plus2,
//   ifid_valid         : IF/ID register contents
//   halted             : fetch stopped on HALT_INSTR
//   fetch_count        : instructions delivered since reset (wraps)
//   misalign_err       : sticky, a redirect target had bit0 set
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [15:0]                redirect_target,
  instr_fetch_unit_if.master         imem,
  output logic [15:0]                ifid_instr,
  output logic [15:0]                ifid_pc_plus2,
  output logic                       ifid_valid,
  output logic                       halted,
  output logic [15:0]                fetch_count,
  output logic                       misalign_err
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic         imem_read_q;
  logic [15:0]  ifid_instr_q;
  logic [15:0]  ifid_pc_plus2_q;
  logic         ifid_valid_q;
  logic         halted_q;
  logic [15:0]  fetch_count_q;
  logic         misalign_q;

  logic [15:0]  next_pc;
  logic         take_redirect;
  logic         take_fetch;
  logic         enter_halt;

  instr_fetch_unit_pc_gen u_pc_gen (
    .pc              (pc_q),
    .state           (state_q),
    .stall           (stall),
    .redirect        (redirect_valid),
    .redirect_target (redirect_target),
    .halt_detect     (imem.imem_data == HALT_INSTR),
    .next_pc         (next_pc),
    .take_redirect   (take_redirect),
    .take_fetch      (take_fetch),
    .enter_halt      (enter_halt)
  );

  // FSM, IF/ID register and counters. imem_read and halted are registered
  // alongside the state so they always reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StBoot;
      pc_q            <= RESET_PC;
      imem_read_q     <= 1'b0;
      ifid_instr_q    <= 16'h0000;
      ifid_pc_plus2_q <= 16'h0000;
      ifid_valid_q    <= 1'b0;
      halted_q        <= 1'b0;
      fetch_count_q   <= 16'h0000;
      misalign_q      <= 1'b0;
    end else begin
      pc_q <= next_pc;
      case (state_q)
        StBoot: begin
          state_q     <= StRun;
          imem_read_q <= 1'b1;
        end
        StRun, StHalt: begin
          if (take_redirect) begin
            state_q      <= StRun;
            imem_read_q  <= 1'b1;
            halted_q     <= 1'b0;
            ifid_valid_q <= 1'b0;
            misalign_q   <= misalign_q | redirect_target[0];
          end else if (take_fetch) begin
            ifid_instr_q    <= imem.imem_data;
            ifid_pc_plus2_q <= pc_q + PcStep;
            ifid_valid_q    <= 1'b1;
            fetch_count_q   <= fetch_count_q + 16'd1;
            // The HALT word itself is still delivered as a valid instruction.
            if (enter_halt) begin
              state_q     <= StHalt;
              imem_read_q <= 1'b0;
              halted_q    <= 1'b1;
            end
          end else if (state_q == StHalt) begin
            ifid_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StBoot;
          imem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_read = imem_read_q;
  assign imem.imem_addr = pc_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_pc_plus2  = ifid_pc_plus2_q;
  assign ifid_valid     = ifid_valid_q;
  assign halted         = halted_q;
  assign fetch_count    = fetch_count_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver steps a behavioural model
// and queues every expected IF/ID delivery; a monitor pops and compares each
// time the DUT delivers a new instruction.
module tb_instr_fetch_unit;

  localparam logic [15:0] HaltWord = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic        misalign_err;

  logic [15:0] mem [32768];

  instr_fetch_unit_if bus ();

  assign bus.imem_data = mem[bus.imem_addr[15:1]];

  instr_fetch_unit #(
    .RESET_PC   (16'h0000),
    .HALT_INSTR (HaltWord)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (bus.master),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus2   (ifid_pc_plus2),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .fetch_count     (fetch_count),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails = 0;

  // Behavioural model: where fetch is, whether it has started, whether it is stopped.
  logic [15:0] m_pc;
  logic [15:0] m_count;
  bit          m_booting;
  bit          m_halted;
  bit          m_valid;
  bit          m_mis;
  logic [15:0] mon_last;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = 16'h0000;
    m_count   = 16'h0000;
    m_booting = 1'b1;
    m_halted  = 1'b0;
    m_valid   = 1'b0;
    m_mis     = 1'b0;
    exp_q.delete();
    mon_last  = 16'h0000;
  endtask

  // Effect of the coming rising edge under the given inputs.
  task automatic model_step(input bit s, input bit rv, input logic [15:0] rt);
    logic [15:0] w;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (rv) begin
      m_pc     = rt & 16'hFFFE;
      m_valid  = 1'b0;
      m_mis    = m_mis | rt[0];
      m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (!s) begin
      w       = mem[m_pc >> 1];
      m_count = m_count + 16'd1;
      exp_q.push_back('{instr: w, pc_plus2: m_pc + 16'd2, count: m_count});
      m_valid = 1'b1;
      m_pc    = m_pc + 16'd2;
      if (w == HaltWord) m_halted = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("imem_addr", bus.imem_addr, m_pc);
    check("imem_read", {15'd0, bus.imem_read}, {15'd0, !m_booting && !m_halted});
    check("halted", {15'd0, halted}, {15'd0, m_halted});
    check("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
    check("misalign_err", {15'd0, misalign_err}, {15'd0, m_mis});
    check("fetch_count", fetch_count, m_count);
  endtask

  task automatic cycle(input bit s, input bit rv, input logic [15:0] rt);
    @(negedge clk);
    check_outputs();
    stall           = s;
    redirect_valid  = rv;
    redirect_target = rt;
    model_step(s, rv, rt);
  endtask

  // Asserts reset right now (asynchronously), checks the outputs collapse before
  // any clock edge, then releases on the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("reset ifid_instr", ifid_instr, 16'h0000);
    check("reset ifid_pc_plus2", ifid_pc_plus2, 16'h0000);
    @(negedge clk);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
    model_step(1'b0, 1'b0, 16'h0000);
  endtask

  // Monitor: a change of fetch_count marks a new delivery into IF/ID.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fetch_count !== mon_last) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_delivery: got instr %h count %h, required none",
                   ifid_instr, fetch_count);
        end else begin
          mon_e = exp_q.pop_front();
          check("ifid_instr", ifid_instr, mon_e.instr);
          check("ifid_pc_plus2", ifid_pc_plus2, mon_e.pc_plus2);
          check("delivery_count", fetch_count, mon_e.count);
          check("delivery_valid", {15'd0, ifid_valid}, 16'd1);
        end
        mon_last = fetch_count;
      end
    end
  end

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      mem[i] = (w == HaltWord) ? 16'h1234 : w;
    end
    mem[0] = 16'h1A1A;
    mem[1] = 16'h2B2B;
    mem[2] = 16'h3C3C;
    mem[4] = HaltWord;
    model_reset();

    // Reset, boot, then A and B.
    do_reset();
    cycle(0, 0, 16'h0000);
    cycle(0, 0, 16'h0000);
    cycle(0, 0, 16'h0000);  // C, pc -> 6
    // Two stall cycles at pc=6, then resume.
    cycle(1, 0, 16'h0000);
    cycle(1, 0, 16'h0000);
    cycle(0, 0, 16'h0000);
    // Redirect to an odd target under stall.
    cycle(1, 1, 16'h0041);
    cycle(0, 0, 16'h0000);
    // HALT at byte address 8, stall ignored while halted, resume at 0.
    cycle(0, 1, 16'h0008);
    cycle(0, 0, 16'h0000);
    cycle(1, 0, 16'h0000);
    cycle(0, 0, 16'h0000);
    cycle(0, 1, 16'h0000);
    cycle(0, 0, 16'h0000);
    // PC wrap past 16'hFFFE.
    cycle(0, 1, 16'hFFFE);
    cycle(0, 0, 16'h0000);
    cycle(0, 0, 16'h0000);
    cycle(0, 0, 16'h0000);
    // Asynchronous reset while pc=10.
    cycle(0, 1, 16'h000A);
    cycle(0, 0, 16'h0000);
    #2;
    do_reset();

    // Randomised phase; HALT words are sprinkled through memory.
    for (int i = 0; i < 64; i++) mem[$urandom_range(32767)] = HaltWord;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) begin
        @(negedge clk);
        check_outputs();
        #2;
        do_reset();
      end else begin
        cycle($urandom_range(3) == 0, $urandom_range(9) == 0, 16'($urandom));
      end
    end
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
